// File: rtl/mips25_pkg.sv
// Shared definitions for the 1-to-4 lane demultiplexer.
//   lane_sel_t     : 2-bit lane select, {in1,in0}
//   LANE_A..LANE_D : select codes 0..3
//   lane_onehot()  : select code to 4-bit one-hot lane mask (bit0 = lane a)
package mips25_pkg;

  typedef logic [1:0] lane_sel_t;

  localparam lane_sel_t LANE_A = 2'd0;
  localparam lane_sel_t LANE_B = 2'd1;
  localparam lane_sel_t LANE_C = 2'd2;
  localparam lane_sel_t LANE_D = 2'd3;

  function automatic logic [3:0] lane_onehot(input lane_sel_t sel);
    lane_onehot = 4'b0001 << sel;
  endfunction

endpackage

// File: rtl/demux1to4_16b_if.sv
// Bus bundle for demux1to4_16b.
//   din/in0/in1/in_valid/in_ready : input word, lane select, handshake
//   a/b/c/d/out_valid/out_ready   : per-lane outputs and handshake (bit0 = a)
//   acc_cnt                       : accepted-word counter, modulo 256
// master = producer/consumer side (bench), slave = demultiplexer side.
interface demux1to4_16b_if #(
  parameter int unsigned WIDTH = 16
);

  logic [WIDTH-1:0] din;
  logic             in0;
  logic             in1;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] c;
  logic [WIDTH-1:0] d;
  logic [3:0]       out_valid;
  logic [3:0]       out_ready;
  logic [7:0]       acc_cnt;

  modport master (
    output din, in0, in1, in_valid, out_ready,
    input  in_ready, a, b, c, d, out_valid, acc_cnt
  );

  modport slave (
    input  din, in0, in1, in_valid, out_ready,
    output in_ready, a, b, c, d, out_valid, acc_cnt
  );

endinterface

// File: rtl/demux_slot.sv
// One-entry holding register for a single output lane.
//   i_clk, i_rstn : clock, synchronous active-low reset
//   i_wr, i_data  : write strobe (an accepted input for this lane) and word
//   i_ready       : downstream sink ready
//   o_valid       : lane FULL
//   o_data        : held word
//   o_accept      : lane can take a word this cycle (EMPTY, or draining now)
module demux_slot #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             i_clk,
  input  logic             i_rstn,
  input  logic             i_wr,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_ready,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data,
  output logic             o_accept
);

  logic             r_valid;
  logic [WIDTH-1:0] r_data;

  assign o_accept = ~r_valid | i_ready;
  assign o_valid  = r_valid;
  assign o_data   = r_data;

  // A write takes priority over a drain so a full lane refills without a bubble.
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (i_wr) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
    end else if (i_ready) begin
      r_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/demux1to4_16b.sv
// Registered 1-to-4 demultiplexer with per-lane valid/ready.
//   clkpos   : clock, rising edge
//   rstn     : synchronous active-low reset
//   vdd, vss : supply-rail pins, no logical function
//   bus      : demux1to4_16b_if.slave (din, select, handshakes, lanes, acc_cnt)
// Holds only select decode, the in_ready mux and the accept counter; each
// lane is a demux_slot.
module demux1to4_16b
  import mips25_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input logic             clkpos,
  input logic             rstn,
  input logic             vdd,
  input logic             vss,
  demux1to4_16b_if.slave  bus
);

  lane_sel_t        w_sel;
  logic [3:0]       w_sel_onehot;
  logic [3:0]       w_lane_accept;
  logic [3:0]       w_lane_valid;
  logic [3:0]       w_lane_wr;
  logic             w_xfer;
  logic [WIDTH-1:0] w_lane_data [4];
  logic [7:0]       r_acc_cnt;
  logic             w_rails_unused;

  assign w_rails_unused = vdd ^ vss;

  assign w_sel        = lane_sel_t'({bus.in1, bus.in0});
  assign w_sel_onehot = lane_onehot(w_sel);
  assign bus.in_ready = w_lane_accept[w_sel];
  assign w_xfer       = bus.in_valid & bus.in_ready;
  assign w_lane_wr    = w_xfer ? w_sel_onehot : '0;

  demux_slot #(.WIDTH(WIDTH)) u_slot_a (
    .i_clk(clkpos), .i_rstn(rstn), .i_wr(w_lane_wr[LANE_A]), .i_data(bus.din),
    .i_ready(bus.out_ready[LANE_A]), .o_valid(w_lane_valid[LANE_A]),
    .o_data(w_lane_data[LANE_A]), .o_accept(w_lane_accept[LANE_A])
  );

  demux_slot #(.WIDTH(WIDTH)) u_slot_b (
    .i_clk(clkpos), .i_rstn(rstn), .i_wr(w_lane_wr[LANE_B]), .i_data(bus.din),
    .i_ready(bus.out_ready[LANE_B]), .o_valid(w_lane_valid[LANE_B]),
    .o_data(w_lane_data[LANE_B]), .o_accept(w_lane_accept[LANE_B])
  );

  demux_slot #(.WIDTH(WIDTH)) u_slot_c (
    .i_clk(clkpos), .i_rstn(rstn), .i_wr(w_lane_wr[LANE_C]), .i_data(bus.din),
    .i_ready(bus.out_ready[LANE_C]), .o_valid(w_lane_valid[LANE_C]),
    .o_data(w_lane_data[LANE_C]), .o_accept(w_lane_accept[LANE_C])
  );

  demux_slot #(.WIDTH(WIDTH)) u_slot_d (
    .i_clk(clkpos), .i_rstn(rstn), .i_wr(w_lane_wr[LANE_D]), .i_data(bus.din),
    .i_ready(bus.out_ready[LANE_D]), .o_valid(w_lane_valid[LANE_D]),
    .o_data(w_lane_data[LANE_D]), .o_accept(w_lane_accept[LANE_D])
  );

  assign bus.a         = w_lane_data[LANE_A];
  assign bus.b         = w_lane_data[LANE_B];
  assign bus.c         = w_lane_data[LANE_C];
  assign bus.d         = w_lane_data[LANE_D];
  assign bus.out_valid = w_lane_valid;
  assign bus.acc_cnt   = r_acc_cnt;

  always_ff @(posedge clkpos) begin
    if (!rstn) begin
      r_acc_cnt <= '0;
    end else if (w_xfer) begin
      r_acc_cnt <= r_acc_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_demux1to4_16b.sv
module tb_demux1to4_16b;

  logic clk = 1'b0;
  logic rstn;
  logic vdd = 1'b1;
  logic vss = 1'b0;

  demux1to4_16b_if #(.WIDTH(16)) bus ();

  demux1to4_16b #(.WIDTH(16)) dut (
    .clkpos(clk), .rstn(rstn), .vdd(vdd), .vss(vss), .bus(bus)
  );

  always #5 clk = ~clk;

  // Reference state: which lanes hold a word, what word, and words accepted.
  bit        m_full [4];
  bit [15:0] m_data [4];
  int        m_cnt;
  bit        m_ok = 1'b0;

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int cur_sel();
    return {30'd0, bus.in1, bus.in0};
  endfunction

  // Model update: one step of the lane rules per rising edge.
  always @(posedge clk) begin
    if (rstn === 1'b0) begin
      for (int k = 0; k < 4; k++) begin
        m_full[k] = 1'b0;
        m_data[k] = 16'h0000;
      end
      m_cnt = 0;
      m_ok  = 1'b1;
    end else if (m_ok) begin
      int  s;
      bit  take;
      s    = cur_sel();
      take = bus.in_valid && (!m_full[s] || bus.out_ready[s]);
      for (int k = 0; k < 4; k++) begin
        if (take && k == s) begin
          m_full[k] = 1'b1;
          m_data[k] = bus.din;
        end else if (m_full[k] && bus.out_ready[k]) begin
          m_full[k] = 1'b0;
        end
      end
      if (take) m_cnt = (m_cnt + 1) % 256;
    end
  end

  // Compare process: every falling edge once the model is defined.
  always @(negedge clk) begin
    if (m_ok) begin
      logic [3:0] ev;
      int s;
      for (int k = 0; k < 4; k++) ev[k] = m_full[k];
      s = cur_sel();
      chk("out_valid", {28'd0, bus.out_valid}, {28'd0, ev});
      chk("acc_cnt", {24'd0, bus.acc_cnt}, m_cnt);
      chk("in_ready", {31'd0, bus.in_ready}, {31'd0, (!m_full[s] || bus.out_ready[s])});
      if (m_full[0]) chk("a", {16'd0, bus.a}, {16'd0, m_data[0]});
      if (m_full[1]) chk("b", {16'd0, bus.b}, {16'd0, m_data[1]});
      if (m_full[2]) chk("c", {16'd0, bus.c}, {16'd0, m_data[2]});
      if (m_full[3]) chk("d", {16'd0, bus.d}, {16'd0, m_data[3]});
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit v, input int s, input logic [15:0] w, input logic [3:0] ordy);
    bus.in_valid  = v;
    bus.in0       = s[0];
    bus.in1       = s[1];
    bus.din       = w;
    bus.out_ready = ordy;
  endtask

  initial begin
    rstn = 1'b0;
    drive(1'b0, 0, 16'h0000, 4'b0000);
    cyc();
    cyc();
    chk("rst_out_valid", {28'd0, bus.out_valid}, 32'h0);
    chk("rst_acc_cnt", {24'd0, bus.acc_cnt}, 32'h0);
    chk("rst_a", {16'd0, bus.a}, 32'h0);
    chk("rst_d", {16'd0, bus.d}, 32'h0);
    rstn = 1'b1;
    #1;
    chk("rst_in_ready", {31'd0, bus.in_ready}, 32'h1);

    // Word to lane c, all sinks ready.
    drive(1'b1, 2, 16'h1234, 4'b1111);
    cyc();
    bus.in_valid = 1'b0;
    chk("c_first_valid", {28'd0, bus.out_valid}, 32'h4);
    chk("c_first_data", {16'd0, bus.c}, 32'h1234);
    chk("c_first_cnt", {24'd0, bus.acc_cnt}, 32'h1);
    cyc();  // lane c drains

    // Stalled lane a refuses a second word.
    drive(1'b1, 0, 16'hAAAA, 4'b0000);
    cyc();
    drive(1'b1, 0, 16'hBBBB, 4'b0000);
    #1;
    chk("a_stall_ready", {31'd0, bus.in_ready}, 32'h0);
    cyc();
    bus.in_valid = 1'b0;
    chk("a_stall_hold", {16'd0, bus.a}, 32'hAAAA);
    chk("a_stall_cnt", {24'd0, bus.acc_cnt}, 32'h2);

    // Lane b replaced while draining.
    drive(1'b1, 1, 16'h0001, 4'b0000);
    cyc();
    drive(1'b1, 1, 16'h0002, 4'b0010);
    #1;
    chk("b_swap_ready", {31'd0, bus.in_ready}, 32'h1);
    cyc();
    drive(1'b0, 1, 16'h0000, 4'b0000);
    chk("b_swap_data", {16'd0, bus.b}, 32'h0002);
    chk("b_swap_valid", {31'd0, bus.out_valid[1]}, 32'h1);

    // Lane d stalled does not block lane a.
    drive(1'b1, 3, 16'hDDDD, 4'b0000);
    cyc();
    drive(1'b0, 0, 16'h0000, 4'b0001);
    cyc();  // lane a drains, d and b stay
    drive(1'b1, 0, 16'h5555, 4'b0000);
    #1;
    chk("a_indep_ready", {31'd0, bus.in_ready}, 32'h1);
    cyc();
    drive(1'b1, 2, 16'h7777, 4'b0000);
    chk("a_indep_data", {16'd0, bus.a}, 32'h5555);
    chk("d_unchanged", {16'd0, bus.d}, 32'hDDDD);
    cyc();  // lane c filled: all four lanes FULL
    chk("all_full", {28'd0, bus.out_valid}, 32'hF);

    // Reset beats a simultaneous transfer.
    rstn = 1'b0;
    drive(1'b1, 1, 16'h9999, 4'b1111);
    cyc();
    chk("rst2_valid", {28'd0, bus.out_valid}, 32'h0);
    chk("rst2_cnt", {24'd0, bus.acc_cnt}, 32'h0);
    chk("rst2_abcd", {16'd0, bus.a | bus.b | bus.c | bus.d}, 32'h0);
    rstn = 1'b1;

    // 257 words with every lane ready: counter wraps to 1.
    for (int i = 0; i < 257; i++) begin
      drive(1'b1, $urandom_range(0, 3), 16'($urandom), 4'b1111);
      cyc();
    end
    bus.in_valid = 1'b0;
    chk("wrap_cnt", {24'd0, bus.acc_cnt}, 32'h1);
    cyc();

    // Random traffic with occasional reset.
    for (int i = 0; i < 3000; i++) begin
      rstn = ($urandom_range(0, 63) != 0);
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 3), 16'($urandom),
            4'($urandom));
      cyc();
    end
    rstn = 1'b1;
    drive(1'b0, 0, 16'h0000, 4'b0000);
    cyc();
    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/demux1to4_16b.md
DEMUX1TO4_16B -- requirements
Module: demux1to4_16b

Interface
REQ-001 Parameter WIDTH, default 16, data width of the input and of every output lane.
REQ-002 clkpos  input  1  single clock; all state updates on its rising edge.
REQ-003 rstn  input  1  reset; synchronous, active-low.
REQ-004 vdd  input  1  supply-rail pin, kept for schematic/netlist compatibility; no logical function.
REQ-005 vss  input  1  supply-rail pin, kept for schematic/netlist compatibility; no logical function.
REQ-006 din  input  WIDTH  data word to route.
REQ-007 in0  input  1  lane select, LSB.
REQ-008 in1  input  1  lane select, MSB; {in1,in0} = 0 selects a, 1 selects b, 2 selects c, 3 selects d.
REQ-009 in_valid  input  1  din and the select are valid this cycle.
REQ-010 in_ready  output  1  block accepts din this cycle.
REQ-011 a, b, c, d  output  WIDTH each  registered lane data.
REQ-012 out_valid  output  4  per-lane data valid; bit0=a, bit1=b, bit2=c, bit3=d.
REQ-013 out_ready  input  4  per-lane sink ready, same bit order.
REQ-014 acc_cnt  output  8  count of accepted input words, wrapping modulo 256.

Function
REQ-015 Input transfer occurs when in_valid and in_ready are both 1 on a rising clkpos edge.
REQ-016 Output transfer on lane k occurs when out_valid[k] and out_ready[k] are both 1 on a rising clkpos edge.
REQ-017 Each lane holds one entry with two states, EMPTY (out_valid[k]=0) and FULL (out_valid[k]=1).
REQ-018 in_ready is combinational: 1 when the selected lane is EMPTY, or when it is FULL and out_ready of that lane is 1; otherwise 0. in_ready does not depend on in_valid.
REQ-019 On an input transfer, din is written to the selected lane register, and that lane is FULL from the next cycle.
REQ-020 Latency from input transfer to out_valid assertion on the selected lane is exactly 1 cycle; there is no combinational path from din to any lane output.
REQ-021 Simultaneous output transfer and input transfer on the same FULL lane: the new word replaces the old one and the lane stays FULL, with no bubble.
REQ-022 An output transfer with no input transfer to that lane returns the lane to EMPTY.
REQ-023 Lanes are independent; a stalled lane never blocks input addressed to a different lane.
REQ-024 Lane data registers hold their value while the lane is FULL and not being drained; the value of a, b, c or d is unspecified when the lane is EMPTY.
REQ-025 The select is sampled only on an input transfer; a select change while in_valid=0 has no effect.
REQ-026 acc_cnt increments by 1 on each input transfer and wraps from 255 to 0.
REQ-027 At most one lane is written per cycle; any number of lanes may drain in the same cycle.

Reset
REQ-028 When rstn=0 at a clkpos edge: out_valid=4'b0000, a=b=c=d=0, and acc_cnt=0.
REQ-029 Reset overrides any simultaneous input or output transfer; words held or in flight are discarded.
REQ-030 in_ready reflects the empty lanes in the first cycle after reset release.

Structure
REQ-031 Shared package mips25_pkg holds the lane_sel_t typedef (2-bit) and the constants LANE_A..LANE_D = 0..3.
REQ-032 One sub-module, demux_slot, implements a single-lane one-entry holding register with valid/ready; it is instantiated 4 times.
REQ-033 The top level contains only select decode, the in_ready mux and acc_cnt.

Verification
REQ-034 Reset, then send din=16'h1234 with sel=2 and out_ready=4'b1111 -> out_valid=4'b0100 and c=16'h1234 on the next cycle; acc_cnt=1.
REQ-035 out_ready=0; send 16'hAAAA to lane a, then 16'hBBBB to lane a -> first word accepted, in_ready=0 on the second; a holds 16'hAAAA.
REQ-036 Lane b FULL with 16'h0001, out_ready[1]=1, input 16'h0002 to lane b in the same cycle -> accepted; b=16'h0002, out_valid[1] stays 1.
REQ-037 Lane d stalled and FULL, input to lane a -> in_ready=1 and a is updated; d unchanged.
REQ-038 Send 257 words with all lanes ready -> acc_cnt=1.
REQ-039 Assert rstn=0 while all lanes are FULL and in_valid=1 -> next cycle out_valid=0, acc_cnt=0, a..d=0.
